// File: rtl/sd_cmd_pkg.sv
// ---------------------------------------------------------------------------
// sd_cmd_pkg
// Shared definitions for the SD command arbiter slice:
//   - command FSM state encoding (plain localparams for legacy tools)
//   - status word field positions and status code nibbles
//   - setting word field positions
//   - resp_expected(): does a setting word ask for a response at all
// ---------------------------------------------------------------------------
package sd_cmd_pkg;

  // Command FSM states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACC  = 3'd2;
  localparam logic [2:0] ST_WAIT_STAT = 3'd3;
  localparam logic [2:0] ST_STAT_ACK  = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // Status word fields
  localparam int STAT_DONE_BIT   = 6;
  localparam int STAT_CRC_OK_BIT = 5;
  localparam int STAT_TMO_BIT    = 15;

  // Status code nibble values reported by the serial engine
  localparam logic [3:0] CODE_ISSUED     = 4'h1;
  localparam logic [3:0] CODE_SENT       = 4'h2;
  localparam logic [3:0] CODE_RESP_START = 4'h3;
  localparam logic [3:0] CODE_RESP_END   = 4'h4;
  localparam logic [3:0] CODE_RESP_CRC   = 4'h5;
  localparam logic [3:0] CODE_COMPLETE   = 4'h6;

  // Final status word reported when the completion timer expires
  localparam logic [15:0] STAT_TMO_WORD = 16'h8000;

  // Setting word fields
  localparam int SET_RSP_LSB    = 0;
  localparam int SET_RSP_MSB    = 6;
  localparam int SET_CRC_BIT    = 7;
  localparam int SET_DLY_LSB    = 8;
  localparam int SET_DLY_MSB    = 10;
  localparam int SET_BLK_WR_BIT = 11;
  localparam int SET_BLK_RD_BIT = 12;
  localparam int SET_WSEL_LSB   = 13;
  localparam int SET_WSEL_MSB   = 14;

  // A zero response size marks a write-only command with nothing to return
  function automatic logic resp_expected(input logic [15:0] setting);
    return |setting[SET_RSP_MSB:SET_RSP_LSB];
  endfunction

endpackage

// File: rtl/sd_rr_arb2.sv
// ---------------------------------------------------------------------------
// sd_rr_arb2
// Two-way round-robin arbiter. The channel other than the last served one
// wins a tie; the pointer moves only when upd_en is high.
// Ports:
//   SD_CLK_IN  clock
//   RST_IN     asynchronous active-high reset (pointer -> 1, ch0 wins first)
//   req        per-channel request
//   upd_en     commit upd_idx as the last served channel
//   upd_idx    channel that was just served
//   grant_idx  winning channel for the current req pattern
// ---------------------------------------------------------------------------
module sd_rr_arb2 (
  input  logic       SD_CLK_IN,
  input  logic       RST_IN,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_idx,
  output logic       grant_idx
);

  logic last_r;

  // Last-served pointer
  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      last_r <= 1'b1;
    end else if (upd_en) begin
      last_r <= upd_idx;
    end else begin
      last_r <= last_r;
    end
  end

  // Winner select: a lone requester wins, a tie goes away from the pointer
  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_r;
    end else if (req == 2'b10) begin
      grant_idx = 1'b1;
    end else begin
      grant_idx = 1'b0;
    end
  end

endmodule

// File: rtl/sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// sd_cmd_arbiter
// Shares one SD command serial engine between ch0 (register front end) and
// ch1 (data engine). Round-robin grant, engine req/ack handshake, status
// stream consumption; returns the final status and response to the winner.
// Optional build macro: SD_CMD_TIMEOUT_EN adds a completion timer that forces
// a done with status 16'h8000 after TMO_CYCLES waiting cycles.
// Ports:
//   SD_CLK_IN, RST_IN          clock, asynchronous active-high reset
//   GO_IDLE                    synchronous abort of FSM and outputs
//   ch_valid_i/setting/cmd     per-channel request (ch0 in the low slice)
//   ch_done_o/status/resp      one-cycle completion to the granted channel
//   busy_o                     command in flight
//   eng_setting/cmd/req_o      command to engine, eng_ack_i acceptance
//   eng_stat_req_i/ack_o       status handshake, eng_status_i/eng_resp_i
// ---------------------------------------------------------------------------
module sd_cmd_arbiter #(
  parameter int              TMO_W      = 16,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 16'hFFFF
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_IN,
  input  logic        GO_IDLE,
  input  logic [1:0]  ch_valid_i,
  input  logic [31:0] ch_setting_i,
  input  logic [79:0] ch_cmd_i,
  output logic [1:0]  ch_done_o,
  output logic [15:0] ch_status_o,
  output logic [39:0] ch_resp_o,
  output logic        busy_o,
  output logic [15:0] eng_setting_o,
  output logic [39:0] eng_cmd_o,
  output logic        eng_req_o,
  input  logic        eng_ack_i,
  input  logic        eng_stat_req_i,
  output logic        eng_stat_ack_o,
  input  logic [15:0] eng_status_i,
  input  logic [39:0] eng_resp_i
);
  import sd_cmd_pkg::*;

  logic [2:0]  state_r, state_nxt_s;
  logic        grant_s, grant_r;
  logic        start_s, tmo_hit_s;
  logic [15:0] sel_setting_s;
  logic [39:0] sel_cmd_s;
  logic [15:0] status_r;
  logic [39:0] resp_r;
  logic [1:0]  ch_done_r;
  logic [15:0] ch_status_r;
  logic [39:0] ch_resp_r;
  logic        busy_r, eng_req_r, stat_ack_r;
  logic [15:0] eng_setting_r;
  logic [39:0] eng_cmd_r;

  sd_rr_arb2 u_arb (
    .SD_CLK_IN (SD_CLK_IN),
    .RST_IN    (RST_IN),
    .req       (ch_valid_i),
    .upd_en    ((state_r == ST_DONE) & ~GO_IDLE),
    .upd_idx   (grant_r),
    .grant_idx (grant_s)
  );

  // Never start while the engine is busy or still has status to hand over
  assign start_s       = (|ch_valid_i) & eng_ack_i & ~eng_stat_req_i;
  assign sel_setting_s = grant_s ? ch_setting_i[31:16] : ch_setting_i[15:0];
  assign sel_cmd_s     = grant_s ? ch_cmd_i[79:40]     : ch_cmd_i[39:0];

`ifdef SD_CMD_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             waiting_s;

  assign waiting_s = (state_r == ST_WAIT_ACC) | (state_r == ST_WAIT_STAT) |
                     (state_r == ST_STAT_ACK);
  // Last waiting cycle of the allowance
  assign tmo_hit_s = waiting_s &
                     (tmo_cnt_r == (TMO_CYCLES - {{(TMO_W-1){1'b0}}, 1'b1}));

  // Completion timer: restarts on issue, runs while waiting on the engine
  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (GO_IDLE || (state_r == ST_ISSUE)) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (waiting_s && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  // No timer: the block waits on the engine indefinitely. The parameters stay
  // referenced so both builds share one parameter list.
  assign tmo_hit_s = 1'b0 & (TMO_CYCLES == {TMO_W{1'b0}});
`endif

  // Next-state decode; an expired timer overrides any waiting state
  always_comb begin
    state_nxt_s = state_r;
    if (tmo_hit_s) begin
      state_nxt_s = ST_DONE;
    end else begin
      case (state_r)
        ST_IDLE:      state_nxt_s = start_s ? ST_ISSUE : ST_IDLE;
        ST_ISSUE:     state_nxt_s = ST_WAIT_ACC;
        ST_WAIT_ACC:  state_nxt_s = eng_ack_i ? ST_WAIT_ACC : ST_WAIT_STAT;
        ST_WAIT_STAT: state_nxt_s = eng_stat_req_i ? ST_STAT_ACK : ST_WAIT_STAT;
        ST_STAT_ACK: begin
          if (eng_stat_req_i) begin
            state_nxt_s = ST_STAT_ACK;
          end else if (status_r[STAT_DONE_BIT]) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT_STAT;
          end
        end
        ST_DONE:      state_nxt_s = ST_IDLE;
        default:      state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; GO_IDLE clears everything but the pointer
  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN || GO_IDLE) begin
      state_r       <= ST_IDLE;
      grant_r       <= 1'b0;
      status_r      <= 16'h0000;
      resp_r        <= 40'h00_0000_0000;
      ch_done_r     <= 2'b00;
      ch_status_r   <= 16'h0000;
      ch_resp_r     <= 40'h00_0000_0000;
      busy_r        <= 1'b0;
      eng_req_r     <= 1'b0;
      stat_ack_r    <= 1'b0;
      eng_setting_r <= 16'h0000;
      eng_cmd_r     <= 40'h00_0000_0000;
    end else begin
      state_r   <= state_nxt_s;
      ch_done_r <= 2'b00;
      if (tmo_hit_s) begin
        ch_done_r   <= grant_r ? 2'b10 : 2'b01;
        ch_status_r <= STAT_TMO_WORD;
        ch_resp_r   <= 40'h00_0000_0000;
        eng_req_r   <= 1'b0;
        stat_ack_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start_s) begin
              grant_r       <= grant_s;
              eng_setting_r <= sel_setting_s;
              eng_cmd_r     <= sel_cmd_s;
              busy_r        <= 1'b1;
              eng_req_r     <= 1'b1;
              status_r      <= 16'h0000;
              resp_r        <= 40'h00_0000_0000;
            end
          end
          ST_WAIT_ACC: begin
            if (!eng_ack_i) begin
              eng_req_r <= 1'b0;
            end
          end
          ST_WAIT_STAT: begin
            if (eng_stat_req_i) begin
              status_r   <= eng_status_i;
              stat_ack_r <= 1'b1;
              // Write-only commands keep a zero response even on final status
              if (eng_status_i[STAT_DONE_BIT] && resp_expected(eng_setting_r)) begin
                resp_r <= eng_resp_i;
              end
            end
          end
          ST_STAT_ACK: begin
            if (!eng_stat_req_i) begin
              stat_ack_r <= 1'b0;
              if (status_r[STAT_DONE_BIT]) begin
                ch_done_r   <= grant_r ? 2'b10 : 2'b01;
                ch_status_r <= status_r;
                ch_resp_r   <= resp_r;
              end
            end
          end
          ST_DONE: begin
            busy_r <= 1'b0;
          end
          default: begin
            busy_r <= busy_r;
          end
        endcase
      end
    end
  end

  assign ch_done_o      = ch_done_r;
  assign ch_status_o    = ch_status_r;
  assign ch_resp_o      = ch_resp_r;
  assign busy_o         = busy_r;
  assign eng_setting_o  = eng_setting_r;
  assign eng_cmd_o      = eng_cmd_r;
  assign eng_req_o      = eng_req_r;
  assign eng_stat_ack_o = stat_ack_r;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sd_cmd_arbiter
// Directed self-checking bench for sd_cmd_arbiter. A behavioural engine task
// accepts commands and streams status words; a negedge monitor records done
// pulses and status-ack handshakes. Inputs change and outputs are sampled on
// the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sd_cmd_arbiter;

  logic        clk, rst, go_idle;
  logic [1:0]  ch_valid;
  logic [31:0] ch_setting;
  logic [79:0] ch_cmd;
  logic [1:0]  ch_done_o;
  logic [15:0] ch_status_o;
  logic [39:0] ch_resp_o;
  logic        busy_o;
  logic [15:0] eng_setting_o;
  logic [39:0] eng_cmd_o;
  logic        eng_req_o;
  logic        eng_ack_i;
  logic        eng_stat_req_i;
  logic        eng_stat_ack_o;
  logic [15:0] eng_status_i;
  logic [39:0] eng_resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int          done_cnt = 0;
  int          ack_cnt  = 0;
  logic        ack_prev = 1'b0;
  logic [1:0]  last_done   = 2'b00;
  logic [15:0] last_status = 16'h0000;
  logic [39:0] last_resp   = 40'h0;

  localparam logic [15:0] S0 = 16'h0000;
  localparam logic [15:0] S1 = 16'h00AE;
  localparam logic [39:0] C0 = 40'h4000000000;
  localparam logic [39:0] C1 = 40'h4900000000;
  localparam logic [39:0] R1 = 40'h0D00000900;
  localparam logic [39:0] RJUNK = 40'h123456789A;

  sd_cmd_arbiter #(.TMO_W(16), .TMO_CYCLES(16'd100)) dut (
    .SD_CLK_IN      (clk),
    .RST_IN         (rst),
    .GO_IDLE        (go_idle),
    .ch_valid_i     (ch_valid),
    .ch_setting_i   (ch_setting),
    .ch_cmd_i       (ch_cmd),
    .ch_done_o      (ch_done_o),
    .ch_status_o    (ch_status_o),
    .ch_resp_o      (ch_resp_o),
    .busy_o         (busy_o),
    .eng_setting_o  (eng_setting_o),
    .eng_cmd_o      (eng_cmd_o),
    .eng_req_o      (eng_req_o),
    .eng_ack_i      (eng_ack_i),
    .eng_stat_req_i (eng_stat_req_i),
    .eng_stat_ack_o (eng_stat_ack_o),
    .eng_status_i   (eng_status_i),
    .eng_resp_i     (eng_resp_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record done pulses and rising edges of the status acknowledge
  always @(negedge clk) begin
    if (ch_done_o != 2'b00) begin
      done_cnt    = done_cnt + 1;
      last_done   = ch_done_o;
      last_status = ch_status_o;
      last_resp   = ch_resp_o;
    end
    if (eng_stat_ack_o && !ack_prev) ack_cnt = ack_cnt + 1;
    ack_prev = eng_stat_ack_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: waits for a request, optionally stalls acceptance, accepts,
  // then hands over n status words (stats[15:0] first). Returns on the
  // falling edge where the last acknowledge drops.
  task automatic engine_run(input int acc_hold, input int n, input logic [63:0] stats,
                            input logic [39:0] resp, input logic [39:0] exp_cmd,
                            input logic [15:0] exp_set);
    int   k;
    logic ok;
    k = 0;
    while (eng_req_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("eng_req_rise", eng_req_o, 1);
    check("eng_cmd", eng_cmd_o, exp_cmd);
    check("eng_setting", eng_setting_o, exp_set);
    check("busy_in_flight", busy_o, 1);
    ok = 1'b1;
    for (int i = 0; i < acc_hold; i++) begin
      @(negedge clk);
      if (eng_req_o !== 1'b1 || eng_cmd_o !== exp_cmd || eng_setting_o !== exp_set) ok = 1'b0;
    end
    if (acc_hold > 0) check("req_cmd_stable_while_stalled", ok, 1);
    eng_ack_i = 1'b0;
    k = 0;
    while (eng_req_o !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    check("eng_req_drop", eng_req_o, 0);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      eng_status_i   = stats[16*s +: 16];
      eng_resp_i     = resp;
      eng_stat_req_i = 1'b1;
      k = 0;
      while (eng_stat_ack_o !== 1'b1 && k < 10) begin @(negedge clk); k++; end
      check("stat_ack_rise", eng_stat_ack_o, 1);
      eng_stat_req_i = 1'b0;
      k = 0;
      while (eng_stat_ack_o !== 1'b0 && k < 10) begin @(negedge clk); k++; end
      check("stat_ack_fall", eng_stat_ack_o, 0);
    end
    eng_ack_i = 1'b1;
  endtask

  initial begin
    int d0, a0, k;
    rst = 1'b1; go_idle = 1'b0; ch_valid = 2'b00;
    ch_setting = {S1, S0}; ch_cmd = {C1, C0};
    eng_ack_i = 1'b1; eng_stat_req_i = 1'b0;
    eng_status_i = 16'h0000; eng_resp_i = 40'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset_done_status", {ch_done_o, ch_status_o}, 0);
    check("reset_resp", ch_resp_o, 0);
    check("reset_ctrl", {busy_o, eng_req_o, eng_stat_ack_o}, 0);
    check("reset_eng_words", {eng_setting_o, eng_cmd_o}, 0);

    // Pending engine status blocks a grant
    eng_stat_req_i = 1'b1; ch_valid = 2'b01;
    repeat (3) @(negedge clk);
    check("no_grant_while_stat_req", {busy_o, eng_req_o}, 0);
    eng_stat_req_i = 1'b0;

    // ch0 write-only command: response must stay zero
    d0 = done_cnt;
    engine_run(0, 2, {32'h0, 16'h0044, 16'h0002}, RJUNK, C0, S0);
    ch_valid = 2'b00;
    @(negedge clk);
    check("t1_done_count", done_cnt - d0, 1);
    check("t1_done_vec", last_done, 2'b01);
    check("t1_status", last_status, 16'h0044);
    check("t1_resp", last_resp, 0);
    check("t1_busy_after", busy_o, 0);

    // ch1 R1 command with three intermediate statuses
    ch_valid = 2'b10; d0 = done_cnt; a0 = ack_cnt;
    engine_run(0, 4, {16'h0066, 16'h0005, 16'h0003, 16'h0001}, R1, C1, S1);
    ch_valid = 2'b00;
    @(negedge clk);
    check("t2_done_count", done_cnt - d0, 1);
    check("t2_done_vec", last_done, 2'b10);
    check("t2_status", last_status, 16'h0066);
    check("t2_resp", last_resp, R1);
    check("t2_ack_handshakes", ack_cnt - a0, 4);

    // Stalled acceptance: engine keeps ack high for 20 cycles
    ch_valid = 2'b10; d0 = done_cnt;
    engine_run(20, 1, {48'h0, 16'h0066}, R1, C1, S1);
    ch_valid = 2'b00;
    @(negedge clk);
    check("t3_done_count", done_cnt - d0, 1);
    check("t3_done_vec", last_done, 2'b10);

    // Both channels requesting continuously: grants alternate from ch0
    ch_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i[0] == 1'b0) engine_run(0, 1, {48'h0, 16'h0044}, RJUNK, C0, S0);
      else              engine_run(0, 1, {48'h0, 16'h0066}, R1, C1, S1);
      if (i == 3) ch_valid = 2'b00;
      @(negedge clk);
      check("rr_grant", last_done, (i[0] == 1'b0) ? 2'b01 : 2'b10);
    end

    // GO_IDLE while waiting for status
    ch_valid = 2'b01; d0 = done_cnt;
    k = 0;
    while (eng_req_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("gi_req_rise", eng_req_o, 1);
    eng_ack_i = 1'b0;
    k = 0;
    while (eng_req_o !== 1'b0 && k < 10) begin @(negedge clk); k++; end
    check("gi_req_drop", eng_req_o, 0);
    go_idle = 1'b1; ch_valid = 2'b00; eng_ack_i = 1'b1;
    @(negedge clk);
    go_idle = 1'b0;
    check("gi_ctrl_cleared", {busy_o, eng_req_o, eng_stat_ack_o}, 0);
    check("gi_cmd_cleared", eng_cmd_o, 0);
    repeat (3) @(negedge clk);
    check("gi_no_done", done_cnt - d0, 0);
    // Pointer untouched by the abort: ch0 still wins the tie
    ch_valid = 2'b11; d0 = done_cnt;
    engine_run(0, 1, {48'h0, 16'h0044}, RJUNK, C0, S0);
    ch_valid = 2'b00;
    @(negedge clk);
    check("gi_next_done_count", done_cnt - d0, 1);
    check("gi_next_done_vec", last_done, 2'b01);
    check("gi_next_status", last_status, 16'h0044);

`ifdef SD_CMD_TIMEOUT_EN
    // Engine accepts but never reports status
    ch_valid = 2'b01;
    k = 0;
    while (eng_req_o !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("tmo_req_rise", eng_req_o, 1);
    eng_ack_i = 1'b0;
    k = 0;
    while (ch_done_o == 2'b00 && k < 200) begin @(negedge clk); k++; end
    check("tmo_latency_window", (k >= 99) && (k <= 102), 1);
    check("tmo_done_vec", ch_done_o, 2'b01);
    check("tmo_status", ch_status_o, 16'h8000);
    check("tmo_resp", ch_resp_o, 0);
    check("tmo_ctrl", {eng_req_o, eng_stat_ack_o}, 0);
    ch_valid = 2'b00; eng_ack_i = 1'b1;
    @(negedge clk);
    check("tmo_busy_after", busy_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
